ex_mem_stage_ctrl: RTL and testbench

//  Reader side of the ID/EX pipeline register: captures execute-stage results and ID/EX control into the EX/MEM latch.

---
 rtl/ex_mem_stage_ctrl.sv | 146 ++++++++++++++
 tb/tb_ex_mem_stage_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_ctrl.sv
// EX/MEM pipeline latch with data-memory request control.
// Holds the request until dhit and stalls upstream while waiting.
module ex_mem_stage_ctrl #(
   parameter int MAX_WAIT = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        flush,
   input  logic        dREN_ID_EX,
   input  logic        dWEN_ID_EX,
   input  logic        WEN_ID_EX,
   input  logic        halt_ID_EX,
   input  logic [4:0]  wsel_EX,
   input  logic [31:0] alu_out_EX,
   input  logic [31:0] rdat2_ID_EX,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dmemload,
   output logic        WEN_EX_MEM,
   output logic [4:0]  wsel_EX_MEM,
   output logic [31:0] alu_out_EX_MEM,
   output logic [31:0] dload_EX_MEM,
   output logic        halt_EX_MEM,
   output logic        mem_stall,
   output logic        dwait_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state_q, state_d;
   logic          ld_q, ld_d;
   logic          st_q, st_d;
   logic          wen_q, wen_d;
   logic          halt_q, halt_d;
   logic [4:0]    wsel_q, wsel_d;
   logic [31:0]   alu_q, alu_d;
   logic [31:0]   sdat_q, sdat_d;
   logic [31:0]   dload_q, dload_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          stall;
   logic          advance;

   assign stall   = (state_q == ACCESS) & ~dhit;
   assign advance = ihit & ~stall & ~halt_q;

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      st_d    = st_q;
      wen_d   = wen_q;
      halt_d  = halt_q;
      wsel_d  = wsel_q;
      alu_d   = alu_q;
      sdat_d  = sdat_q;
      dload_d = dload_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (state_q == ACCESS) begin
         if (dhit) begin
            state_d = IDLE;
            if (ld_q) dload_d = dmemload;
         end else if (cnt_q != MAXW) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // a new instruction replaces the latch, so its load slot starts empty
      if (advance) begin
         if (flush) begin
            ld_d    = 1'b0;
            st_d    = 1'b0;
            wen_d   = 1'b0;
            halt_d  = 1'b0;
            wsel_d  = '0;
            alu_d   = '0;
            sdat_d  = '0;
            dload_d = '0;
         end else begin
            ld_d    = dREN_ID_EX & ~dWEN_ID_EX & ~halt_ID_EX;
            st_d    = dWEN_ID_EX & ~halt_ID_EX;
            wen_d   = WEN_ID_EX;
            halt_d  = halt_ID_EX;
            wsel_d  = wsel_EX;
            alu_d   = alu_out_EX;
            sdat_d  = rdat2_ID_EX;
            dload_d = '0;
            if (~halt_ID_EX & (dREN_ID_EX | dWEN_ID_EX)) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end
         end
      end

      if (cnt_d == MAXW) err_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         wen_q   <= 1'b0;
         halt_q  <= 1'b0;
         wsel_q  <= '0;
         alu_q   <= '0;
         sdat_q  <= '0;
         dload_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         wen_q   <= wen_d;
         halt_q  <= halt_d;
         wsel_q  <= wsel_d;
         alu_q   <= alu_d;
         sdat_q  <= sdat_d;
         dload_q <= dload_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign dREN           = (state_q == ACCESS) & ld_q;
   assign dWEN           = (state_q == ACCESS) & st_q;
   assign daddr          = alu_q;
   assign dstore         = sdat_q;
   assign WEN_EX_MEM     = wen_q;
   assign wsel_EX_MEM    = wsel_q;
   assign alu_out_EX_MEM = alu_q;
   assign dload_EX_MEM   = dload_q;
   assign halt_EX_MEM    = halt_q;
   assign mem_stall      = stall;
   assign dwait_err      = err_q;

endmodule

// File: tb/tb_ex_mem_stage_ctrl.sv
// Randomised and directed bench for ex_mem_stage_ctrl against a
// transaction-level model of the EX/MEM latch and memory request.
module tb_ex_mem_stage_ctrl;

   localparam int MAXW = 64;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0, dhit = 1'b0, flush = 1'b0;
   logic        dREN_ID_EX = 1'b0, dWEN_ID_EX = 1'b0;
   logic        WEN_ID_EX = 1'b0, halt_ID_EX = 1'b0;
   logic [4:0]  wsel_EX = '0;
   logic [31:0] alu_out_EX = '0, rdat2_ID_EX = '0, dmemload = '0;
   logic        dREN, dWEN, WEN_EX_MEM, halt_EX_MEM, mem_stall, dwait_err;
   logic [31:0] daddr, dstore, alu_out_EX_MEM, dload_EX_MEM;
   logic [4:0]  wsel_EX_MEM;

   ex_mem_stage_ctrl #(.MAX_WAIT(MAXW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
      .dREN_ID_EX(dREN_ID_EX), .dWEN_ID_EX(dWEN_ID_EX),
      .WEN_ID_EX(WEN_ID_EX), .halt_ID_EX(halt_ID_EX),
      .wsel_EX(wsel_EX), .alu_out_EX(alu_out_EX),
      .rdat2_ID_EX(rdat2_ID_EX), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .dmemload(dmemload),
      .WEN_EX_MEM(WEN_EX_MEM), .wsel_EX_MEM(wsel_EX_MEM),
      .alu_out_EX_MEM(alu_out_EX_MEM), .dload_EX_MEM(dload_EX_MEM),
      .halt_EX_MEM(halt_EX_MEM), .mem_stall(mem_stall),
      .dwait_err(dwait_err)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // model: the latched instruction and whether its request is outstanding
   logic        m_pend, m_ld, m_st, m_wen, m_halt, m_err, m_stall, m_adv;
   logic [4:0]  m_wsel;
   logic [31:0] m_addr, m_sdat, m_dload;
   int          m_waited;
   logic [138:0] ev, av;

   task automatic model_clear();
      m_pend = 0; m_ld = 0; m_st = 0; m_wen = 0; m_halt = 0; m_err = 0;
      m_wsel = '0; m_addr = '0; m_sdat = '0; m_dload = '0; m_waited = 0;
   endtask

   // inputs change only at posedge+1, so at negedge they are what the
   // next rising edge will sample
   initial begin
      model_clear();
      forever begin
         @(negedge CLK);
         if (!nRST) begin
            model_clear();
         end else begin
            m_stall = m_pend && !dhit;
            ev = {m_pend & m_ld, m_pend & m_st, m_addr, m_sdat, m_wen,
                  m_wsel, m_addr, m_dload, m_halt, m_stall, m_err};
            av = {dREN, dWEN, daddr, dstore, WEN_EX_MEM, wsel_EX_MEM,
                  alu_out_EX_MEM, dload_EX_MEM, halt_EX_MEM, mem_stall,
                  dwait_err};
            n_cmp++;
            if (av !== ev) begin
               n_bad++;
               $display("FAIL cycle_model t=%0t got %h expected %h",
                        $time, av, ev);
            end
            m_adv = ihit && !m_stall && !m_halt;
            if (m_pend && dhit) begin
               if (m_ld) m_dload = dmemload;
               m_pend = 0;
            end else if (m_pend) begin
               if (m_waited < MAXW) m_waited++;
               if (m_waited == MAXW) m_err = 1;
            end
            if (m_adv) begin
               if (flush) begin
                  m_ld = 0; m_st = 0; m_wen = 0; m_halt = 0;
                  m_wsel = '0; m_addr = '0; m_sdat = '0; m_dload = '0;
               end else begin
                  m_st = dWEN_ID_EX && !halt_ID_EX;
                  m_ld = dREN_ID_EX && !dWEN_ID_EX && !halt_ID_EX;
                  m_wen = WEN_ID_EX; m_halt = halt_ID_EX;
                  m_wsel = wsel_EX; m_addr = alu_out_EX;
                  m_sdat = rdat2_ID_EX; m_dload = '0;
                  if (m_ld || m_st) begin
                     m_pend = 1;
                     m_waited = 0;
                  end
               end
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      ihit = 0; dhit = 0; flush = 0; dREN_ID_EX = 0; dWEN_ID_EX = 0;
      WEN_ID_EX = 0; halt_ID_EX = 0; wsel_EX = '0; alu_out_EX = '0;
      rdat2_ID_EX = '0; dmemload = '0;
   endtask

   task automatic do_reset();
      nRST = 0;
      idle_in();
      step();
      step();
      nRST = 1;
      step();
   endtask

   task automatic latch(logic ld, logic st, logic wen, logic hlt,
                        logic fl, logic [31:0] alu, logic [31:0] d);
      idle_in();
      ihit = 1; dREN_ID_EX = ld; dWEN_ID_EX = st; WEN_ID_EX = wen;
      halt_ID_EX = hlt; flush = fl; alu_out_EX = alu; rdat2_ID_EX = d;
      wsel_EX = 5'd9;
      step();
      idle_in();
   endtask

   int ren_n, wen_n, stl_n, rise;
   int hit_pct;

   initial begin
      idle_in();
      step();
      #1;
      chk("reset_dREN", 32'(dREN), 0);
      chk("reset_stall", 32'(mem_stall), 0);
      chk("reset_err", 32'(dwait_err), 0);
      chk("reset_alu", alu_out_EX_MEM, 0);
      do_reset();

      // load, dhit three cycles after request
      latch(1, 0, 1, 0, 0, 32'h40, 0);
      ren_n = 0; stl_n = 0;
      for (int i = 0; i < 6; i++) begin
         dhit = (i == 3); dmemload = 32'hDEADBEEF;
         #1;
         ren_n += int'(dREN); stl_n += int'(mem_stall);
         if (i == 0) chk("load_daddr", daddr, 32'h40);
         step();
      end
      idle_in();
      chk("load_dREN_cycles", ren_n, 4);
      chk("load_stall_cycles", stl_n, 3);
      chk("load_data", dload_EX_MEM, 32'hDEADBEEF);

      // store hit on the first request cycle
      latch(0, 1, 0, 0, 0, 32'h80, 32'h1234);
      wen_n = 0; stl_n = 0;
      for (int i = 0; i < 4; i++) begin
         dhit = (i == 0);
         #1;
         wen_n += int'(dWEN); stl_n += int'(mem_stall);
         if (i == 0) chk("store_dstore", dstore, 32'h1234);
         step();
      end
      idle_in();
      chk("store_dWEN_cycles", wen_n, 1);
      chk("store_stall_cycles", stl_n, 0);

      // flushed store becomes a bubble
      latch(0, 1, 1, 0, 1, 32'h44, 32'h55);
      wen_n = 0;
      for (int i = 0; i < 4; i++) begin
         #1; wen_n += int'(dWEN); step();
      end
      chk("flush_dWEN_cycles", wen_n, 0);
      chk("flush_WEN", 32'(WEN_EX_MEM), 0);

      // flush during a stall is ignored
      latch(1, 0, 1, 0, 0, 32'h100, 0);
      ihit = 1; flush = 1; alu_out_EX = 32'h999; dWEN_ID_EX = 1;
      step();
      step();
      #1;
      chk("stallflush_alu", alu_out_EX_MEM, 32'h100);
      chk("stallflush_dREN", 32'(dREN), 1);
      idle_in();
      dhit = 1; dmemload = 32'h77;
      step();
      idle_in();
      #1;
      chk("stallflush_done", 32'(dREN), 0);
      chk("stallflush_load", dload_EX_MEM, 32'h77);

      // halt is sticky and blocks the latch
      latch(1, 0, 0, 1, 0, 32'h55, 0);
      ren_n = 0;
      for (int i = 0; i < 4; i++) begin
         ihit = 1; alu_out_EX = 32'hAAAA + i; dREN_ID_EX = 1;
         #1; ren_n += int'(dREN); step();
      end
      idle_in();
      chk("halt_sticky", 32'(halt_EX_MEM), 1);
      chk("halt_alu_held", alu_out_EX_MEM, 32'h55);
      chk("halt_no_req", ren_n, 0);
      do_reset();

      // withheld dhit, then asynchronous reset mid-request
      latch(1, 0, 0, 0, 0, 32'h200, 0);
      rise = -1;
      for (int i = 0; i < 70; i++) begin
         #1;
         if (dwait_err && rise < 0) rise = i;
         step();
      end
      chk("wait_err_cycle", rise, MAXW);
      chk("wait_dREN_held", 32'(dREN), 1);
      #2;
      nRST = 0;
      #1;
      chk("async_dREN", 32'(dREN), 0);
      chk("async_err", 32'(dwait_err), 0);
      do_reset();

      // randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) hit_pct = (c == 1000) ? 2 : 35;
         if ((m_halt && $urandom_range(0, 9) == 0) ||
             $urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            ihit = ($urandom_range(0, 99) < 55);
            dhit = ($urandom_range(0, 99) < hit_pct);
            flush = ($urandom_range(0, 99) < 15);
            dREN_ID_EX = ($urandom_range(0, 99) < 35);
            dWEN_ID_EX = ($urandom_range(0, 99) < 25);
            WEN_ID_EX = $urandom_range(0, 1) == 1;
            halt_ID_EX = ($urandom_range(0, 199) == 0);
            wsel_EX = 5'($urandom);
            alu_out_EX = $urandom;
            rdat2_ID_EX = $urandom;
            dmemload = $urandom;
            step();
         end
      end
      idle_in();
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
